// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - requester handshake and SPI pin bundle for spi_master_ctrl
interface spi_master_ctrl_if;
  logic [7:0] txData;
  logic       txLast;
  logic       txValid;
  logic       txReady;
  logic [7:0] rxData;
  logic       rxValid;
  logic       busy;
  logic       cs;
  logic       sck;
  logic       mosi;
  logic       miso;

  modport master (
    input  txData, txLast, txValid, miso,
    output txReady, rxData, rxValid, busy, cs, sck, mosi
  );

  modport slave (
    output txData, txLast, txValid, miso,
    input  txReady, rxData, rxValid, busy, cs, sck, mosi
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - mode-0 MSB-first SPI byte master with burst chip-select sequencing
module spi_master_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_LO,
    SCK_HI,
    WAIT_NEXT,
    HOLD,
    GAP
  } state_t;

  // SETUP spends one extra cycle before cs falls, so its terminal count is CS_SETUP itself.
  localparam logic [15:0] DIV_END   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_END = 16'(CS_SETUP);
  localparam logic [15:0] HOLD_END  = 16'(CS_HOLD - 1);
  localparam logic [15:0] IDLE_END  = 16'(CS_IDLE - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;
  logic        last_flag;
  logic        accept;

  assign bus.txReady = (state == IDLE) || (state == WAIT_NEXT);
  assign bus.busy    = (state != IDLE);
  assign accept      = bus.txValid && bus.txReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      bit_cnt     <= 3'd0;
      tx_sh       <= 8'd0;
      rx_sh       <= 8'd0;
      last_flag   <= 1'b0;
      bus.cs      <= 1'b1;
      bus.sck     <= 1'b0;
      bus.mosi    <= 1'b0;
      bus.rxData  <= 8'd0;
      bus.rxValid <= 1'b0;
    end else begin
      bus.rxValid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_sh     <= bus.txData;
            last_flag <= bus.txLast;
            cnt       <= 16'd0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          bus.cs   <= 1'b0;
          bus.mosi <= tx_sh[7];
          if (cnt == SETUP_END) begin
            cnt     <= 16'd0;
            bit_cnt <= 3'd0;
            state   <= SCK_LO;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SCK_LO: begin
          if (cnt == DIV_END) begin
            cnt     <= 16'd0;
            bus.sck <= 1'b1;
            state   <= SCK_HI;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SCK_HI: begin
          if (cnt == DIV_END) begin
            cnt     <= 16'd0;
            bus.sck <= 1'b0;
            rx_sh   <= {rx_sh[6:0], bus.miso};
            // Falling edge: sample miso before the peripheral shifts, then present the next bit.
            if (bit_cnt == 3'd7) begin
              bus.rxData  <= {rx_sh[6:0], bus.miso};
              bus.rxValid <= 1'b1;
              state       <= last_flag ? HOLD : WAIT_NEXT;
            end else begin
              tx_sh    <= {tx_sh[6:0], 1'b0};
              bus.mosi <= tx_sh[6];
              bit_cnt  <= bit_cnt + 3'd1;
              state    <= SCK_LO;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_NEXT: begin
          if (accept) begin
            tx_sh     <= bus.txData;
            last_flag <= bus.txLast;
            bus.mosi  <= bus.txData[7];
            cnt       <= 16'd0;
            bit_cnt   <= 3'd0;
            state     <= SCK_LO;
          end
        end
        HOLD: begin
          if (cnt == HOLD_END) begin
            cnt      <= 16'd0;
            bus.cs   <= 1'b1;
            bus.mosi <= 1'b0;
            state    <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          if (cnt == IDLE_END) begin
            cnt   <= 16'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - randomized scoreboard bench for spi_master_ctrl with a behavioural SPI peripheral
module tb_spi_master_ctrl;
  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_ctrl_if dut_if();
  spi_master_ctrl_if fast_if();

  spi_master_ctrl #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(dut_if.master));

  spi_master_ctrl #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1))
    u_fast (.clk(clk), .rst_n(rst_n), .bus(fast_if.master));

  assign fast_if.miso = fast_if.mosi;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endfunction

  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] resp_tab[256];
  int         acc_total = 0;
  bit         last_acc_flag = 1'b0;
  bit         mon_en = 1'b0;

  // Peripheral: presents bit 7 at cs fall, shifts on each sck fall, captures mosi on sck rise.
  int         pcount = 0;
  int         bitidx = 0;
  int         cap_n = 0;
  logic [7:0] cap = 8'd0;
  logic       pp_cs = 1'b1;
  logic       pp_sck = 1'b0;
  always @(dut_if.cs, dut_if.sck, rst_n) begin
    if (!rst_n) begin
      if (bitidx != 0 || cap_n != 0) pcount++;
      bitidx = 0;
      cap_n = 0;
      pp_cs = 1'b1;
      pp_sck = 1'b0;
      dut_if.miso = 1'b0;
    end else begin
      if (dut_if.sck !== pp_sck) begin
        if (dut_if.sck === 1'b1) begin
          cap = {cap[6:0], dut_if.mosi};
          cap_n++;
          if (cap_n == 8) begin
            cap_n = 0;
            if (exp_tx.size() == 0) chk("mosi_unexpected_byte", 1, 0);
            else chk("mosi_byte", int'(cap), int'(exp_tx.pop_front()));
          end
        end else begin
          bitidx++;
          if (bitidx == 8) begin
            bitidx = 0;
            pcount++;
          end
          dut_if.miso = resp_tab[pcount % 256][7 - bitidx];
        end
      end
      if (dut_if.cs !== pp_cs) begin
        if (dut_if.cs === 1'b0) begin
          bitidx = 0;
          cap_n = 0;
          dut_if.miso = resp_tab[pcount % 256][7];
        end else begin
          if (bitidx != 0 || cap_n != 0) pcount++;
          bitidx = 0;
          cap_n = 0;
        end
      end
      pp_cs = dut_if.cs;
      pp_sck = dut_if.sck;
    end
  end

  // Monitor: scoreboard pop on rxValid plus cs/sck protocol rules.
  logic p_cs = 1'b1;
  logic p_sck = 1'b0;
  int   last_fall = 0;
  int   last_cs_rise = -1000;
  int   burst_start = 0;
  int   burst_rises = 0;
  always @(posedge clk) begin
    #1;
    if (!mon_en) begin
      p_cs = 1'b1;
      p_sck = 1'b0;
      burst_rises = 0;
    end else begin
      if (dut_if.rxValid) begin
        if (exp_rx.size() == 0) chk("rx_unexpected", 1, 0);
        else chk("rx_data", int'(dut_if.rxData), int'(exp_rx.pop_front()));
      end
      if (dut_if.sck != p_sck) begin
        chk("sck_toggle_with_cs_low", int'(dut_if.cs), 0);
        if (dut_if.sck) burst_rises++;
        else last_fall = cyc;
      end
      if (dut_if.cs != p_cs) begin
        chk("cs_change_with_sck_low", int'({p_sck, dut_if.sck}), 0);
        if (!dut_if.cs) begin
          chk("cs_idle_min", int'((cyc - last_cs_rise) >= CS_IDLE), 1);
          burst_start = acc_total - 1;
          burst_rises = 0;
        end else begin
          chk("cs_hold", cyc - last_fall, CS_HOLD);
          chk("burst_sck_pulses", burst_rises, 8 * (acc_total - burst_start));
          chk("burst_ends_on_last", int'(last_acc_flag), 1);
          last_cs_rise = cyc;
        end
      end
      p_cs = dut_if.cs;
      p_sck = dut_if.sck;
    end
  end

  task automatic send(input logic [7:0] d, input bit last, input bit keep, output int acc_cyc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!dut_if.txReady && guard < 2000) begin
      if (dut_if.txValid) begin
        dut_if.txData = 8'($urandom);
        dut_if.txLast = 1'($urandom);
      end
      guard++;
      @(negedge clk);
    end
    if (guard >= 2000) chk("send_ready_timeout", 0, 1);
    dut_if.txData = d;
    dut_if.txLast = last;
    dut_if.txValid = 1'b1;
    @(posedge clk);
    exp_tx.push_back(d);
    exp_rx.push_back(resp_tab[acc_total % 256]);
    acc_total++;
    last_acc_flag = last;
    #1;
    acc_cyc = cyc;
    if (keep) begin
      dut_if.txData = 8'($urandom);
      dut_if.txLast = 1'($urandom);
    end else begin
      dut_if.txValid = 1'b0;
    end
  endtask

  task automatic wait_rx(output int c);
    int guard;
    guard = 0;
    c = -1;
    while (guard < 500) begin
      @(posedge clk);
      #1;
      if (dut_if.rxValid) begin
        c = cyc;
        break;
      end
      if (dut_if.txValid) dut_if.txData = 8'($urandom);
      guard++;
    end
    if (c < 0) chk("wait_rx_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while ((dut_if.busy || !dut_if.txReady) && guard < 1000);
    if (guard >= 1000) chk("wait_idle_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, c, len, rises, n, k;
    int cs_f, rise_f, rxv_f, rxv_n, cs_r, rdy;
    logic ps;
    logic [7:0] d;
    bit keep;

    for (int i = 0; i < 256; i++) resp_tab[i] = 8'($urandom);
    resp_tab[0] = 8'h3C;
    dut_if.txData = 8'd0;
    dut_if.txLast = 1'b0;
    dut_if.txValid = 1'b0;
    fast_if.txData = 8'd0;
    fast_if.txLast = 1'b0;
    fast_if.txValid = 1'b0;

    #12;
    chk("reset_cs", int'(dut_if.cs), 1);
    chk("reset_sck", int'(dut_if.sck), 0);
    chk("reset_mosi", int'(dut_if.mosi), 0);
    chk("reset_rxData", int'(dut_if.rxData), 0);
    chk("reset_rxValid", int'(dut_if.rxValid), 0);
    chk("reset_busy", int'(dut_if.busy), 0);
    chk("reset_txReady", int'(dut_if.txReady), 1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Single byte 0xA5, edge-accurate timing.
    send(8'hA5, 1'b1, 1'b0, a);
    cs_f = -1; rise_f = -1; rxv_f = -1; rxv_n = 0; cs_r = -1; rdy = -1; rises = 0; ps = 1'b0;
    for (int e = 1; e <= 90; e++) begin
      @(posedge clk);
      #1;
      if (cs_f < 0 && !dut_if.cs) cs_f = e;
      if (dut_if.sck && !ps) begin
        rises++;
        if (rise_f < 0) rise_f = e;
      end
      ps = dut_if.sck;
      if (dut_if.rxValid) begin
        rxv_n++;
        if (rxv_f < 0) begin
          rxv_f = e;
          chk("t1_rxData", int'(dut_if.rxData), 8'h3C);
        end
      end
      if (cs_f >= 0 && cs_r < 0 && dut_if.cs) cs_r = e;
      if (cs_r >= 0 && rdy < 0 && dut_if.txReady) rdy = e;
    end
    chk("t1_cs_fall_edge", cs_f, 1);
    chk("t1_first_rise_edge", rise_f, 1 + CS_SETUP + CLK_DIV);
    chk("t1_sck_pulses", rises, 8);
    chk("t1_rxValid_edge", rxv_f, 1 + CS_SETUP + 16 * CLK_DIV);
    chk("t1_rxValid_pulses", rxv_n, 1);
    chk("t1_cs_rise_edge", cs_r, 1 + CS_SETUP + 16 * CLK_DIV + CS_HOLD);
    chk("t1_txReady_edge", rdy, 1 + CS_SETUP + 16 * CLK_DIV + CS_HOLD + CS_IDLE);

    // Three-byte burst with txValid held: one-cycle WAIT_NEXT between bytes.
    send(8'h01, 1'b0, 1'b1, a);
    wait_rx(c);
    send(8'h80, 1'b0, 1'b1, a);
    chk("burst_wait_next_gap1", a - c, 1);
    wait_rx(c);
    send(8'hFF, 1'b1, 1'b0, a);
    chk("burst_wait_next_gap2", a - c, 1);
    wait_idle();

    // Parked in WAIT_NEXT for 50 cycles, then resume without setup delay.
    send(8'($urandom), 1'b0, 1'b0, a);
    wait_rx(c);
    for (int e = 0; e < 50; e++) begin
      @(posedge clk);
      #1;
      chk("wait_next_park", int'({dut_if.cs, dut_if.sck, dut_if.busy, dut_if.txReady}), 4'b0011);
    end
    send(8'($urandom), 1'b1, 1'b0, a);
    n = 0;
    while (!dut_if.sck && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("resume_first_rise", n, CLK_DIV);
    wait_idle();

    // Random bursts; held txValid toggles data while the controller is busy.
    for (int b = 0; b < 12; b++) begin
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        d = 8'($urandom);
        keep = (b == 11 && i == len - 1) ? 1'b0 : 1'($urandom);
        send(d, (i == len - 1), keep, a);
        if (!keep) begin
          k = $urandom_range(0, 5);
          repeat (k) @(posedge clk);
        end
      end
    end
    wait_idle();

    // Asynchronous reset with sck high during bit 3.
    send(8'hC3, 1'b1, 1'b0, a);
    rises = 0;
    ps = 1'b0;
    n = 0;
    while (rises < 4 && n < 200) begin
      @(posedge clk);
      #1;
      if (dut_if.sck && !ps) rises++;
      ps = dut_if.sck;
      n++;
    end
    chk("reset_test_reached_bit3", int'(dut_if.sck), 1);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_reset_cs", int'(dut_if.cs), 1);
    chk("async_reset_sck", int'(dut_if.sck), 0);
    chk("async_reset_rxValid", int'(dut_if.rxValid), 0);
    chk("async_reset_busy", int'(dut_if.busy), 0);
    exp_rx.delete();
    exp_tx.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    send(8'h96, 1'b1, 1'b0, a);
    wait_idle();

    // Minimum-timing instance with loopback.
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 8'h5A : 8'($urandom);
      @(negedge clk);
      fast_if.txData = d;
      fast_if.txLast = 1'b1;
      fast_if.txValid = 1'b1;
      @(posedge clk);
      #1;
      fast_if.txValid = 1'b0;
      n = 0;
      while (!fast_if.rxValid && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("fast_done_edge", n, 18);
      chk("fast_loopback_data", int'(fast_if.rxData), int'(d));
      repeat (4) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_rx_drained", exp_rx.size(), 0);
    chk("scoreboard_tx_drained", exp_tx.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
